// File: rtl/spi_buffer_arbiter.sv
// spi_buffer_arbiter: two-requester round-robin arbiter and sequencer in front
// of the MOSI SPI buffer (requester 0 = init/command engine, 1 = draw engine).
// Optional macro ARB_TIMEOUT_EN adds a WAIT-state watchdog of TIMEOUT cycles.
module spi_buffer_arbiter #(
    parameter int WIDTH   = 8,
    parameter int N       = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic               i_SCK,
    input  logic               i_RST,
    input  logic               i_REQ0,
    input  logic [WIDTH*N-1:0] i_DATA0,
    input  logic [N-1:0]       i_DC0,
    input  logic [4:0]         i_NTX0,
    input  logic               i_REQ1,
    input  logic [WIDTH*N-1:0] i_DATA1,
    input  logic [N-1:0]       i_DC1,
    input  logic [4:0]         i_NTX1,
    input  logic               i_TX_DONE,
    output logic               o_GNT0,
    output logic               o_GNT1,
    output logic               o_DONE0,
    output logic               o_DONE1,
    output logic               o_ERR,
    output logic [WIDTH*N-1:0] o_DATA,
    output logic [N-1:0]       o_DC,
    output logic [4:0]         o_NTX,
    output logic               o_START,
    output logic               o_BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT
    } state_t;

    state_t             state_q;
    logic               ptr_q;      // requester favoured on a tie
    logic               owner_q;    // requester owning the buffer
    logic               gnt0_q;
    logic               gnt1_q;
    logic               done0_q;
    logic               done1_q;
    logic               err_q;
    logic               start_q;
    logic               busy_q;
    logic [WIDTH*N-1:0] data_q;
    logic [N-1:0]       dc_q;
    logic [4:0]         ntx_q;

`ifdef ARB_TIMEOUT_EN
    logic [15:0]        cnt_q;
`else
    logic               unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    logic               win_vld;
    logic               win_sel;
    logic               win_bad;
    logic [WIDTH*N-1:0] win_data;
    logic [N-1:0]       win_dc;
    logic [4:0]         win_ntx;

    // Select the winner among current requests; the pointer breaks a tie
    always_comb begin
        win_vld  = i_REQ0 | i_REQ1;
        win_sel  = (i_REQ0 & i_REQ1) ? ptr_q : i_REQ1;
        win_data = win_sel ? i_DATA1 : i_DATA0;
        win_dc   = win_sel ? i_DC1   : i_DC0;
        win_ntx  = win_sel ? i_NTX1  : i_NTX0;
        win_bad  = (win_ntx == 5'd0) || (32'(win_ntx) > 32'(N));
    end

    // Arbitration / sequencing FSM with registered outputs
    always_ff @(posedge i_SCK) begin
        if (i_RST) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            dc_q    <= '0;
            ntx_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_vld) begin
                        data_q  <= win_data;
                        dc_q    <= win_dc;
                        ntx_q   <= win_ntx;
                        gnt0_q  <= ~win_sel;
                        gnt1_q  <= win_sel;
                        ptr_q   <= ~win_sel;
                        owner_q <= win_sel;
                        if (win_bad) begin
                            // Rejected length: grant, done and error in one cycle
                            done0_q <= ~win_sel;
                            done1_q <= win_sel;
                            err_q   <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    start_q <= 1'b1;
                    state_q <= ST_WAIT;
`ifdef ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                ST_WAIT: begin
                    if (i_TX_DONE) begin
                        done0_q <= ~owner_q;
                        done1_q <= owner_q;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (cnt_q == 16'(TIMEOUT - 1)) begin
                        done0_q <= ~owner_q;
                        done1_q <= owner_q;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q   <= cnt_q + 16'd1;
                    end
`endif
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_GNT0  = gnt0_q;
    assign o_GNT1  = gnt1_q;
    assign o_DONE0 = done0_q;
    assign o_DONE1 = done1_q;
    assign o_ERR   = err_q;
    assign o_START = start_q;
    assign o_BUSY  = busy_q;
    assign o_DATA  = data_q;
    assign o_DC    = dc_q;
    assign o_NTX   = ntx_q;

endmodule

// File: tb/tb_spi_buffer_arbiter.sv
// Self-checking bench for spi_buffer_arbiter: transaction-level reference
// model compared every cycle, plus directed literal expectations.
// Build with ARB_TIMEOUT_EN defined to exercise the watchdog (TIMEOUT=16).
module tb_spi_buffer_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
    localparam bit TO_ON      = 1'b1;
`else
    localparam int TB_TIMEOUT = 1024;
    localparam bit TO_ON      = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, tx_done;
    logic [63:0] data0, data1;
    logic [7:0]  dc0, dc1;
    logic [4:0]  ntx0, ntx1;
    logic        gnt0, gnt1, done0, done1, err, start, busy;
    logic [63:0] odata;
    logic [7:0]  odc;
    logic [4:0]  ontx;

    spi_buffer_arbiter #(.WIDTH(8), .N(8), .TIMEOUT(TB_TIMEOUT)) dut (
        .i_SCK(clk), .i_RST(rst),
        .i_REQ0(req0), .i_DATA0(data0), .i_DC0(dc0), .i_NTX0(ntx0),
        .i_REQ1(req1), .i_DATA1(data1), .i_DC1(dc1), .i_NTX1(ntx1),
        .i_TX_DONE(tx_done),
        .o_GNT0(gnt0), .o_GNT1(gnt1), .o_DONE0(done0), .o_DONE1(done1),
        .o_ERR(err), .o_DATA(odata), .o_DC(odc), .o_NTX(ontx),
        .o_START(start), .o_BUSY(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a transaction is "busy" from grant to completion;
    // its age counts edges since grant (age 1 = start, later = waiting).
    logic [1:0]  e_gnt, e_done;
    logic        e_err, e_start, e_busy;
    logic [63:0] e_data;
    logic [7:0]  e_dc;
    logic [4:0]  e_ntx;
    bit          m_busy = 0, m_owner = 0, m_fav = 0;
    int          m_age  = 0;

    initial begin
        e_gnt = '0; e_done = '0; e_err = 0; e_start = 0; e_busy = 0;
        e_data = '0; e_dc = '0; e_ntx = '0;
    end

    always @(posedge clk) begin : model
        bit         w;
        logic [4:0] nw;
        e_gnt = '0; e_done = '0; e_err = 0; e_start = 0;
        if (rst) begin
            m_busy = 0; m_fav = 0; m_owner = 0; m_age = 0;
            e_data = '0; e_dc = '0; e_ntx = '0;
        end else if (!m_busy) begin
            if (req0 || req1) begin
                w      = (req0 && req1) ? m_fav : req1;
                nw     = w ? ntx1 : ntx0;
                e_data = w ? data1 : data0;
                e_dc   = w ? dc1 : dc0;
                e_ntx  = nw;
                e_gnt[w] = 1'b1;
                m_fav  = !w;
                if (nw == 0 || nw > 8) begin
                    e_done[w] = 1'b1;
                    e_err     = 1'b1;
                end else begin
                    m_busy = 1; m_owner = w; m_age = 0;
                end
            end
        end else begin
            m_age++;
            if (m_age == 1) e_start = 1'b1;
            else if (tx_done) begin
                e_done[m_owner] = 1'b1;
                m_busy = 0;
            end else if (TO_ON && m_age == TB_TIMEOUT + 1) begin
                e_done[m_owner] = 1'b1;
                e_err  = 1'b1;
                m_busy = 0;
            end
        end
        e_busy = m_busy;
    end

    // Compare every output against the model each cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt0",  gnt0,  e_gnt[0]);
            check("gnt1",  gnt1,  e_gnt[1]);
            check("done0", done0, e_done[0]);
            check("done1", done1, e_done[1]);
            check("err",   err,   e_err);
            check("start", start, e_start);
            check("busy",  busy,  e_busy);
            check("data",  odata, e_data);
            check("dc",    odc,   e_dc);
            check("ntx",   ontx,  e_ntx);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1; req0 = 0; req1 = 0; tx_done = 0;
        cyc(); cyc();
        rst = 0;
    endtask

    int          n, ndone;
    bit          errseen;
    int          gq[$];
    logic [63:0] held;

    initial begin
        rst = 1; req0 = 0; req1 = 0; tx_done = 0;
        data0 = '0; data1 = '0; dc0 = '0; dc1 = '0; ntx0 = '0; ntx1 = '0;
        cyc();
        chk_en = 1;
        cyc();
        rst = 0;
        cyc();
        check("rst_busy", busy, 0);
        check("rst_data", odata, 0);
        check("rst_ntx",  ontx, 0);

        // Single requester 0 transaction
        req0 = 1; ntx0 = 5'd8; data0 = 64'h8040201008040201; dc0 = 8'hAA;
        cyc();
        check("t1_gnt0", gnt0, 1);
        check("t1_data", odata, 64'h8040201008040201);
        check("t1_dc",   odc, 8'hAA);
        check("t1_ntx",  ontx, 8);
        req0 = 0;
        cyc();
        check("t1_start", start, 1);
        cyc(); cyc(); cyc();
        tx_done = 1;
        cyc();
        tx_done = 0;
        check("t1_done0", done0, 1);
        check("t1_busy",  busy, 0);

        // Both held: round-robin order after reset
        do_reset();
        req0 = 1; req1 = 1;
        ndone = 0;
        gq.delete();
        for (int i = 0; i < 300 && ndone < 4; i++) begin
            data0 = {$urandom, $urandom}; data1 = {$urandom, $urandom};
            dc0 = 8'($urandom); dc1 = 8'($urandom);
            ntx0 = 5'($urandom_range(1, 8)); ntx1 = 5'($urandom_range(1, 8));
            tx_done = ($urandom % 4 == 0);
            cyc();
            if (gnt0) gq.push_back(0);
            if (gnt1) gq.push_back(1);
            if (done0 || done1) ndone++;
        end
        req0 = 0; req1 = 0; tx_done = 0;
        check("t2_done_count", ndone, 4);
        check("t2_gnt_count", gq.size(), 4);
        if (gq.size() >= 4) begin
            check("t2_order0", gq[0], 0);
            check("t2_order1", gq[1], 1);
            check("t2_order2", gq[2], 0);
            check("t2_order3", gq[3], 1);
        end
        cyc();

        // Rejected lengths 0 and 9
        for (int k = 0; k < 2; k++) begin
            req1 = 1; ntx1 = (k == 0) ? 5'd0 : 5'd9;
            cyc();
            req1 = 0;
            check("t3_gnt1",  gnt1, 1);
            check("t3_done1", done1, 1);
            check("t3_err",   err, 1);
            check("t3_busy",  busy, 0);
            cyc();
            check("t3_nostart", start, 0);
        end

        // Payload held during WAIT; done with a simultaneous new request
        req0 = 1; ntx0 = 5'd3; data0 = {$urandom, $urandom}; held = data0;
        cyc();
        req0 = 0;
        for (int i = 0; i < 4; i++) begin
            data0 = {$urandom, $urandom};
            cyc();
            check("t4_hold", odata, held);
        end
        tx_done = 1; req1 = 1; ntx1 = 5'd2; data1 = {$urandom, $urandom};
        cyc();
        tx_done = 0;
        check("t4_done0", done0, 1);
        check("t4_data_at_done", odata, held);
        check("t4_no_gnt1_yet", gnt1, 0);
        cyc();
        req1 = 0;
        check("t4_gnt1", gnt1, 1);
        cyc(); cyc();
        tx_done = 1;
        cyc();
        tx_done = 0;

        // Reset during WAIT wins over a coincident transmit-done
        req1 = 1; ntx1 = 5'd4;
        cyc();
        req1 = 0;
        cyc(); cyc();
        rst = 1; tx_done = 1;
        cyc();
        rst = 0; tx_done = 0;
        check("t5_nodone", done1, 0);
        check("t5_busy",   busy, 0);
        check("t5_data",   odata, 0);
        req0 = 1; req1 = 1; ntx0 = 5'd1; ntx1 = 5'd1;
        cyc();
        req0 = 0; req1 = 0;
        check("t5_gnt0", gnt0, 1);
        check("t5_gnt1", gnt1, 0);
        cyc(); cyc();
        tx_done = 1;
        cyc();
        tx_done = 0;

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom % 64 == 0);
            req0    = ($urandom % 3 == 0);
            req1    = ($urandom % 3 == 0);
            ntx0    = 5'($urandom_range(0, 12));
            ntx1    = 5'($urandom_range(0, 12));
            data0   = {$urandom, $urandom}; data1 = {$urandom, $urandom};
            dc0     = 8'($urandom); dc1 = 8'($urandom);
            tx_done = ($urandom % 5 == 0);
            cyc();
        end

        // Watchdog behaviour
        do_reset();
        req0 = 1; ntx0 = 5'd3;
        cyc();
        req0 = 0;
        cyc();
        check("t6_start", start, 1);
`ifdef ARB_TIMEOUT_EN
        n = 0; errseen = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            n++;
            if (done0) begin
                errseen = err;
                break;
            end
        end
        check("t6_timeout_latency", n, 16);
        check("t6_timeout_err", errseen, 1);
`else
        for (int i = 0; i < 2000; i++) cyc();
        check("t6_busy_held", busy, 1);
        tx_done = 1;
        cyc();
        tx_done = 0;
        check("t6_done0", done0, 1);
        check("t6_err", err, 0);
`endif
        cyc();
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "time limit");
    end

endmodule
